// File: rtl/nor_flash_slave_pkg.sv
// rtl/nor_flash_slave_pkg.sv - shared constants, command codes and FSM state type
// Erase command is only honoured when NOR_PROGRAM_SEMANTICS_EN is defined.
package nor_flash_slave_pkg;
  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_ERASE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    OP_READ,
    OP_WRITE,
    OP_ERASE
  } op_t;
endpackage

// File: rtl/nfs_edge_det.sv
// rtl/nfs_edge_det.sv - registers the serial clock and flags its rising edge
module nfs_edge_det (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_s_clk,
  output logic o_edge
);
  logic r_s_clk_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_s_clk_q <= 1'b0;
    else         r_s_clk_q <= i_s_clk;
  end

  assign o_edge = i_s_clk & ~r_s_clk_q;
endmodule

// File: rtl/nor_flash_slave.sv
// rtl/nor_flash_slave.sv - byte-serial NOR flash model: read/write/erase on a word array
// Optional NOR_PROGRAM_SEMANTICS_EN: AND-programming plus the erase command.
module nor_flash_slave
  import nor_flash_slave_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] ERASE_VAL = 32'hFFFF_FFFF
) (
  input  logic                  p_clk,
  input  logic                  p_reset,
  input  logic                  s_clk,
  input  logic                  s_css,
  input  logic [BYTE_W-1:0]     s_mosi,
  output logic [BYTE_W-1:0]     s_miso,
  output logic                  cmd_err,
  output logic                  wr_done
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_t            r_state, w_next;
  op_t               r_op;
  logic [1:0]        r_bcnt;
  logic [AW-1:0]     r_idx;
  logic [23:0]       r_shift;
  logic              r_wr_pend;
  logic [AW-1:0]     r_wr_idx;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_cmd_err;
  logic              w_edge, w_take, w_cmd_err_set;
  logic [AW-1:0]     w_addr_idx;
  logic [DATA_W-1:0] w_commit, w_rd_word;
`ifdef NOR_PROGRAM_SEMANTICS_EN
  logic              r_wr_erase;
`endif

  nfs_edge_det u_edge_det (
    .i_clk   (p_clk),
    .i_reset (p_reset),
    .i_s_clk (s_clk),
    .o_edge  (w_edge)
  );

  // Deselect has priority, so an edge arriving with s_css high is never taken.
  assign w_take     = w_edge & ~s_css;
  // Only the bits covering DEPTH are kept; they all live in the last address byte.
  assign w_addr_idx = s_mosi[AW-1:0];

  always_comb begin
    w_next        = r_state;
    w_cmd_err_set = 1'b0;
    if (s_css) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_next = ST_CMD;
        ST_CMD: if (w_take) begin
          case (s_mosi)
            CMD_READ, CMD_WRITE: w_next = ST_ADDR;
`ifdef NOR_PROGRAM_SEMANTICS_EN
            CMD_ERASE:           w_next = ST_ADDR;
`endif
            default: begin
              w_next        = ST_IGNORE;
              w_cmd_err_set = 1'b1;
            end
          endcase
        end
        ST_ADDR: if (w_take && r_bcnt == 2'd2) begin
          case (r_op)
            OP_READ:  w_next = ST_RDATA;
            OP_WRITE: w_next = ST_WDATA;
            default:  w_next = ST_IGNORE;
          endcase
        end
        default: w_next = r_state;
      endcase
    end
  end

`ifdef NOR_PROGRAM_SEMANTICS_EN
  assign w_commit = r_wr_erase ? ERASE_VAL : (r_mem[r_wr_idx] & r_wr_data);
`else
  assign w_commit = r_wr_data;
`endif

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_READ;
      r_bcnt    <= 2'd0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_wr_pend <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
      r_cmd_err <= 1'b0;
`ifdef NOR_PROGRAM_SEMANTICS_EN
      r_wr_erase <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= ERASE_VAL;
    end else begin
      r_state   <= w_next;
      r_cmd_err <= w_cmd_err_set;
      r_wr_pend <= 1'b0;
`ifdef NOR_PROGRAM_SEMANTICS_EN
      r_wr_erase <= 1'b0;
`endif
      if (r_wr_pend) r_mem[r_wr_idx] <= w_commit;
      if (s_css) begin
        r_bcnt <= 2'd0;
      end else if (w_take) begin
        case (r_state)
          ST_CMD: begin
            r_bcnt <= 2'd0;
            if (s_mosi == CMD_WRITE)      r_op <= OP_WRITE;
            else if (s_mosi == CMD_ERASE) r_op <= OP_ERASE;
            else                          r_op <= OP_READ;
          end
          ST_ADDR: begin
            r_bcnt <= (r_bcnt == 2'd2) ? 2'd0 : r_bcnt + 2'd1;
            if (r_bcnt == 2'd2) begin
              r_idx <= w_addr_idx;
`ifdef NOR_PROGRAM_SEMANTICS_EN
              if (r_op == OP_ERASE) begin
                r_wr_pend  <= 1'b1;
                r_wr_erase <= 1'b1;
                r_wr_idx   <= w_addr_idx;
              end
`endif
            end
          end
          ST_WDATA: begin
            r_bcnt  <= r_bcnt + 2'd1;
            r_shift <= {r_shift[15:0], s_mosi};
            if (r_bcnt == 2'd3) begin
              r_wr_pend <= 1'b1;
              r_wr_idx  <= r_idx;
              r_wr_data <= {r_shift, s_mosi};
              r_idx     <= r_idx + AW'(1);
            end
          end
          ST_RDATA: begin
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) r_idx <= r_idx + AW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign w_rd_word = r_mem[r_idx];

  always_comb begin
    s_miso = '0;
    if (r_state == ST_RDATA) begin
      case (r_bcnt)
        2'd0: s_miso = w_rd_word[31:24];
        2'd1: s_miso = w_rd_word[23:16];
        2'd2: s_miso = w_rd_word[15:8];
        default: s_miso = w_rd_word[7:0];
      endcase
    end
  end

  assign cmd_err = r_cmd_err;
  assign wr_done = r_wr_pend;
endmodule

// File: tb/tb_nor_flash_slave.sv
// tb/tb_nor_flash_slave.sv - directed and randomized checks against a word-array model
// Adds program/erase checks when NOR_PROGRAM_SEMANTICS_EN is defined.
module tb_nor_flash_slave;
  localparam int          DEPTH = 16;
  localparam logic [31:0] ERASE = 32'hFFFF_FFFF;

  logic       p_clk = 1'b0;
  logic       p_reset, s_clk, s_css;
  logic [7:0] s_mosi, s_miso;
  logic       cmd_err, wr_done;

  int n_checks = 0;
  int n_err    = 0;
  int wr_cnt   = 0;
  int err_cnt  = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [7:0]  byte_q [$];
  logic [7:0]  v;

  nor_flash_slave #(.DEPTH(DEPTH), .ERASE_VAL(ERASE)) dut (
    .p_clk   (p_clk),
    .p_reset (p_reset),
    .s_clk   (s_clk),
    .s_css   (s_css),
    .s_mosi  (s_mosi),
    .s_miso  (s_miso),
    .cmd_err (cmd_err),
    .wr_done (wr_done)
  );

  always #5 p_clk = ~p_clk;

  always @(negedge p_clk) begin
    if (wr_done) wr_cnt++;
    if (cmd_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] combine(input logic [31:0] old_w, input logic [31:0] new_w);
`ifdef NOR_PROGRAM_SEMANTICS_EN
    return old_w & new_w;
`else
    return new_w;
`endif
  endfunction

  task automatic sel();
    @(negedge p_clk);
    s_css = 1'b0;
    repeat (2) @(negedge p_clk);
  endtask

  task automatic send(input logic [7:0] b);
    s_mosi = b;
    s_clk  = 1'b1;
    repeat (2) @(negedge p_clk);
    s_clk  = 1'b0;
    repeat (2) @(negedge p_clk);
  endtask

  task automatic desel();
    s_css = 1'b1;
    repeat (3) @(negedge p_clk);
  endtask

  task automatic read_byte(output logic [7:0] b);
    b = s_miso;
    send(8'h00);
  endtask

  // Upper address bits are random: the slave must ignore them.
  task automatic send_addr(input int idx);
    send(8'($urandom));
    send(8'($urandom));
    send(8'(idx) | 8'($urandom_range(0, 15) << 4));
  endtask

  task automatic write_q(input int idx);
    sel();
    send(8'h02);
    send_addr(idx);
    foreach (byte_q[i]) send(byte_q[i]);
    desel();
    for (int w = 0; w < byte_q.size() / 4; w++) begin
      int k = (idx + w) % DEPTH;
      ref_mem[k] = combine(ref_mem[k], {byte_q[4*w], byte_q[4*w+1], byte_q[4*w+2], byte_q[4*w+3]});
    end
  endtask

  task automatic read_check(input int idx, input int nwords, input string tag);
    sel();
    send(8'h01);
    send_addr(idx);
    for (int w = 0; w < nwords; w++)
      for (int b = 0; b < 4; b++) begin
        read_byte(v);
        check(tag, {24'h0, v}, {24'h0, 8'(ref_mem[(idx + w) % DEPTH] >> (24 - 8*b))});
      end
    desel();
  endtask

  task automatic do_reset();
    p_reset = 1'b1;
    s_css   = 1'b1;
    s_clk   = 1'b0;
    repeat (3) @(negedge p_clk);
    p_reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = ERASE;
    @(negedge p_clk);
  endtask

  initial begin
    s_mosi = 8'h00;
    do_reset();
    check("reset_miso", {24'h0, s_miso}, 32'h0);
    check("reset_cmd_err", {31'h0, cmd_err}, 32'h0);
    check("reset_wr_done", {31'h0, wr_done}, 32'h0);

    wr_cnt = 0;
    byte_q = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    write_q(0);
    check("basic_wr_done", wr_cnt, 1);
    read_check(0, 1, "basic_read");

    read_check(3, 1, "erased_read");

    err_cnt = 0; wr_cnt = 0;
    sel();
    send(8'h55);
    for (int i = 0; i < 4; i++) begin
      read_byte(v);
      check("ignore_miso", {24'h0, v}, 32'h0);
    end
    desel();
    check("bad_cmd_err", err_cnt, 1);
    check("bad_cmd_wr", wr_cnt, 0);
    read_check(0, 1, "bad_cmd_mem");

    wr_cnt = 0;
    byte_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    write_q(15);
    check("wrap_wr_done", wr_cnt, 2);
    read_check(15, 2, "wrap_read");

    wr_cnt = 0;
    byte_q = '{8'hA5, 8'h5A};
    write_q(7);
    check("partial_wr_done", wr_cnt, 0);
    read_check(7, 1, "partial_read");

    for (int it = 0; it < 8; it++) begin
      int idx = $urandom_range(0, DEPTH - 1);
      int nw  = $urandom_range(1, 3);
      int ext = $urandom_range(0, 3);
      byte_q = {};
      for (int i = 0; i < 4*nw + ext; i++) byte_q.push_back(8'($urandom));
      wr_cnt = 0;
      write_q(idx);
      check("rand_wr_done", wr_cnt, nw);
      read_check(idx, nw + 1, "rand_read");
    end

`ifdef NOR_PROGRAM_SEMANTICS_EN
    byte_q = '{8'hF0, 8'hF0, 8'hF0, 8'hF0};
    write_q(1);
    byte_q = '{8'h0F, 8'hFF, 8'hFF, 8'hFF};
    write_q(1);
    sel();
    send(8'h01);
    send_addr(1);
    for (int b = 0; b < 4; b++) begin
      logic [31:0] want;
      want = 32'h00F0F0F0;
      read_byte(v);
      check("program_and", {24'h0, v}, {24'h0, 8'(want >> (24 - 8*b))});
    end
    desel();
    err_cnt = 0; wr_cnt = 0;
    sel();
    send(8'h20);
    send_addr(1);
    desel();
    ref_mem[1] = ERASE;
    check("erase_wr_done", wr_cnt, 1);
    check("erase_cmd_err", err_cnt, 0);
    read_check(1, 1, "erase_read");
`else
    err_cnt = 0; wr_cnt = 0;
    sel();
    send(8'h20);
    send_addr(1);
    desel();
    check("erase_unsup_err", err_cnt, 1);
    check("erase_unsup_wr", wr_cnt, 0);
    read_check(1, 1, "erase_unsup_mem");
`endif

    wr_cnt = 0;
    sel();
    send(8'h02);
    send_addr(2);
    send(8'h12); send(8'h34); send(8'h56);
    do_reset();
    check("abort_wr_done", wr_cnt, 0);
    read_check(2, 1, "abort_read");
    read_check(15, 2, "abort_all_erased");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/nor_flash_slave.md
NOR_FLASH_SLAVE -- requirements
Module: nor_flash_slave

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit flash words (power of two, 2..256).
REQ-002 Parameter ERASE_VAL, default 32'hFFFF_FFFF, content of every word after reset.
REQ-003 p_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 p_reset  input  1  synchronous, active-high reset.
REQ-005 s_clk  input  1  serial clock from controller, sampled in p_clk domain.
REQ-006 s_css  input  1  chip select, active low.
REQ-007 s_mosi  input  8  byte from controller, valid at s_clk rising edge.
REQ-008 s_miso  output  8  read byte to controller.
REQ-009 cmd_err  output  1  one-cycle pulse on unsupported command byte.
REQ-010 wr_done  output  1  one-cycle pulse when a 32-bit word commits to memory.

Function
REQ-011 Edge detect: s_clk registered each cycle as s_clk_q; edge = s_clk & ~s_clk_q; a byte is taken only on an edge cycle while s_css == 0.
REQ-012 FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
REQ-013 IDLE -> CMD when s_css == 0; any state -> IDLE in the cycle s_css == 1, byte counter cleared.
REQ-014 CMD: 8'h01 -> ADDR (read), 8'h02 -> ADDR (write), other -> IGNORE with cmd_err pulse next cycle.
REQ-015 ADDR: three bytes, MSB first, form addr[31:8]; word index = addr[8 +: log2(DEPTH)]; upper bits ignored.
REQ-016 After third address byte: write -> WDATA, read -> RDATA.
REQ-017 WDATA: four bytes assembled MSB first ([31:24] first); word written in the cycle after the fourth edge; wr_done pulses the same cycle.
REQ-018 Further bytes in WDATA continue with index+1, wrapping DEPTH-1 -> 0.
REQ-019 RDATA: s_miso = byte 0 ([31:24]) of the addressed word from the cycle after the third address edge; advances one byte per subsequent edge; after byte 3 advances to next word, same wrap rule.
REQ-020 Deselect mid-word in WDATA discards the partial word; memory unchanged.
REQ-021 IGNORE: all bytes discarded until deselect; s_miso held 8'h00.
REQ-022 s_miso = 8'h00 in every state except RDATA.
REQ-023 Edge coincident with s_css rising: deselect wins, byte discarded.

Reset
REQ-024 On p_reset: state IDLE, counters 0, s_miso 8'h00, cmd_err 0, wr_done 0, s_clk_q 0.
REQ-025 On p_reset every memory word loads ERASE_VAL; reset mid-transaction aborts it with no memory commit.

Configuration
REQ-026 Macro NOR_PROGRAM_SEMANTICS_EN defined: committed word = old AND new (program only clears bits); command 8'h20 followed by three address bytes sets that word to ERASE_VAL on third address edge+1, with wr_done pulse.
REQ-027 Macro undefined: committed word = new data (overwrite); 8'h20 treated as unsupported (cmd_err).

Structure
REQ-028 Shared package holds command constants (CMD_READ 8'h01, CMD_WRITE 8'h02, CMD_ERASE 8'h20), FSM state enum and APB/SPI width constants (32, 8).
REQ-029 One sub-module, nfs_edge_det, holds the s_clk register and edge pulse; memory array and FSM stay in nor_flash_slave.

Verification
REQ-030 Reset, then write cmd 02, addr 00 00 00, data FF 00 FF 00 -> wr_done once; subsequent read cmd 01 addr 00 00 00 -> s_miso sequence FF,00,FF,00.
REQ-031 Read word 3 after reset -> four bytes FF (ERASE_VAL).
REQ-032 Command 8'h55 -> cmd_err single pulse, s_miso 00, no wr_done, memory unchanged.
REQ-033 Write to index 15 with eight data bytes 11..18 -> word15 = 11121314, word0 = 15161718 (wrap).
REQ-034 Write with deselect after two data bytes -> no wr_done, word unchanged.
REQ-035 With NOR_PROGRAM_SEMANTICS_EN: write F0F0F0F0 then 0FFFFFFF to word 1 -> read 00F0F0F0; erase word 1 -> read FFFFFFFF.
